// File: rtl/days_sum_if.sv
// days_sum_if: request/response bundle for days_sum_seq.
//   start   master->slave  request pulse, taken only while the block is idle
//   mode    master->slave  0 = absolute day number of date_a, 1 = date_a - date_b
//   date_a  master->slave  {year, month[3:0], day[4:0]}
//   date_b  master->slave  same packing, used only in mode 1
//   busy    slave->master  operation in progress
//   done    slave->master  one-cycle completion pulse
//   err     slave->master  invalid date seen in the current operation
//   result  slave->master  two's-complement day count / day difference
`timescale 1ns/1ps
interface days_sum_if #(
    parameter int YEAR_W = 14,
    parameter int DAYS_W = 23
);
    logic                start;
    logic                mode;
    logic [YEAR_W+8:0]   date_a;
    logic [YEAR_W+8:0]   date_b;
    logic                busy;
    logic                done;
    logic                err;
    logic [DAYS_W:0]     result;

    modport master (
        output start, mode, date_a, date_b,
        input  busy, done, err, result
    );

    modport slave (
        input  start, mode, date_a, date_b,
        output busy, done, err, result
    );
endinterface

// File: rtl/days_sum_seq.sv
// days_sum_seq: multi-cycle proleptic-Gregorian day counter.
// Mode 0 returns the absolute day number of date_a (0001-01-01 = 1);
// mode 1 returns date_a - date_b in days. Y/4, Y/100 and Y/400 come from
// three restoring radix-2 dividers that share one YEAR_W-cycle DIV phase.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   days_sum_if slave: start/mode/date_a/date_b in, busy/done/err/result out
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start, inputs captured on start
// VALIDATE | range/leap check of date_a (and date_b in mode 1), load Y
// DIV      | YEAR_W iterations of the three parallel dividers
// ACCUM    | assemble the day number; mode 1 first pass re-enters DIV
// DONE     | done pulse, result/err held
`timescale 1ns/1ps
module days_sum_seq #(
    parameter int YEAR_W = 14,
    parameter int DAYS_W = 23
) (
    input  logic       clk,
    input  logic       rst,
    days_sum_if.slave  bus
);
    localparam int DATE_W = YEAR_W + 9;
    // Remainder only ever holds values < 400, so 9 bits plus one shift bit.
    localparam int REM_W  = 10;
    localparam int CNT_W  = $clog2(YEAR_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_DIV,
        S_ACCUM,
        S_DONE
    } state_t;

    function automatic logic [YEAR_W-1:0] f_year(input logic [DATE_W-1:0] d);
        return d[DATE_W-1:9];
    endfunction

    function automatic logic [3:0] f_month(input logic [DATE_W-1:0] d);
        return d[8:5];
    endfunction

    function automatic logic [4:0] f_day(input logic [DATE_W-1:0] d);
        return d[4:0];
    endfunction

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return (((y % YEAR_W'(4)) == '0) && ((y % YEAR_W'(100)) != '0)) ||
               ((y % YEAR_W'(400)) == '0);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        logic [4:0] len;
        case (m)
            4'd2:                      len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction

    function automatic logic date_ok(input logic [DATE_W-1:0] d);
        logic [YEAR_W-1:0] y;
        logic [3:0]        m;
        logic [4:0]        dd;
        y  = f_year(d);
        m  = f_month(d);
        dd = f_day(d);
        return (y != '0) && (m != 4'd0) && (m <= 4'd12) && (dd != 5'd0) &&
               (dd <= month_len(m, is_leap(y)));
    endfunction

    function automatic logic [8:0] cum_days(input logic [3:0] m, input logic leap);
        logic [8:0] c;
        case (m)
            4'd1:    c = 9'd0;
            4'd2:    c = 9'd31;
            4'd3:    c = 9'd59;
            4'd4:    c = 9'd90;
            4'd5:    c = 9'd120;
            4'd6:    c = 9'd151;
            4'd7:    c = 9'd181;
            4'd8:    c = 9'd212;
            4'd9:    c = 9'd243;
            4'd10:   c = 9'd273;
            4'd11:   c = 9'd304;
            default: c = 9'd334;
        endcase
        if (leap && (m > 4'd2)) begin
            c = c + 9'd1;
        end
        return c;
    endfunction

    // One restoring step on the {remainder, dividend/quotient} pair: shift the
    // next dividend bit into the remainder and subtract the divisor if it fits.
    function automatic logic [REM_W+YEAR_W-1:0] div_step(
        input logic [REM_W+YEAR_W-1:0] rq,
        input logic [REM_W-1:0]        dv
    );
        logic [REM_W+YEAR_W-1:0] sh;
        logic [REM_W-1:0]        r;
        logic [YEAR_W-1:0]       q;
        sh = rq << 1;
        r  = sh[REM_W+YEAR_W-1:YEAR_W];
        q  = sh[YEAR_W-1:0];
        if (r >= dv) begin
            r    = r - dv;
            q[0] = 1'b1;
        end
        return {r, q};
    endfunction

    state_t              state_q,  state_d;
    logic                mode_q,   mode_d;
    logic [DATE_W-1:0]   date_a_q, date_a_d;
    logic [DATE_W-1:0]   date_b_q, date_b_d;
    logic                pass_q,   pass_d;
    logic                leap_a_q, leap_a_d;
    logic                leap_b_q, leap_b_d;
    logic [YEAR_W-1:0]   y_q,      y_d;
    logic [YEAR_W-1:0]   q4_q,     q4_d;
    logic [YEAR_W-1:0]   q100_q,   q100_d;
    logic [YEAR_W-1:0]   q400_q,   q400_d;
    logic [REM_W-1:0]    r4_q,     r4_d;
    logic [REM_W-1:0]    r100_q,   r100_d;
    logic [REM_W-1:0]    r400_q,   r400_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DAYS_W-1:0]   d_a_q,    d_a_d;
    logic                err_q,    err_d;
    logic [DAYS_W:0]     result_q, result_d;

    logic [3:0]          sel_m;
    logic [4:0]          sel_day;
    logic                sel_leap;
    logic [DAYS_W-1:0]   acc_sum;
    logic                valid_a;
    logic                valid_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            date_a_q <= '0;
            date_b_q <= '0;
            pass_q   <= 1'b0;
            leap_a_q <= 1'b0;
            leap_b_q <= 1'b0;
            y_q      <= '0;
            q4_q     <= '0;
            q100_q   <= '0;
            q400_q   <= '0;
            r4_q     <= '0;
            r100_q   <= '0;
            r400_q   <= '0;
            cnt_q    <= '0;
            d_a_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            date_a_q <= date_a_d;
            date_b_q <= date_b_d;
            pass_q   <= pass_d;
            leap_a_q <= leap_a_d;
            leap_b_q <= leap_b_d;
            y_q      <= y_d;
            q4_q     <= q4_d;
            q100_q   <= q100_d;
            q400_q   <= q400_d;
            r4_q     <= r4_d;
            r100_q   <= r100_d;
            r400_q   <= r400_d;
            cnt_q    <= cnt_d;
            d_a_q    <= d_a_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        date_a_d = date_a_q;
        date_b_d = date_b_q;
        pass_d   = pass_q;
        leap_a_d = leap_a_q;
        leap_b_d = leap_b_q;
        y_d      = y_q;
        q4_d     = q4_q;
        q100_d   = q100_q;
        q400_d   = q400_q;
        r4_d     = r4_q;
        r100_d   = r100_q;
        r400_d   = r400_q;
        cnt_d    = cnt_q;
        d_a_d    = d_a_q;
        err_d    = err_q;
        result_d = result_q;

        sel_m    = pass_q ? f_month(date_b_q) : f_month(date_a_q);
        sel_day  = pass_q ? f_day(date_b_q)   : f_day(date_a_q);
        sel_leap = pass_q ? leap_b_q          : leap_a_q;
        acc_sum  = DAYS_W'(y_q) * DAYS_W'(365)
                 + DAYS_W'(q4_q) - DAYS_W'(q100_q) + DAYS_W'(q400_q)
                 + DAYS_W'(cum_days(sel_m, sel_leap)) + DAYS_W'(sel_day);
        valid_a  = date_ok(date_a_q);
        valid_b  = !mode_q || date_ok(date_b_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    date_a_d = bus.date_a;
                    date_b_d = bus.date_b;
                    state_d  = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                err_d    = 1'b0;
                leap_a_d = is_leap(f_year(date_a_q));
                leap_b_d = is_leap(f_year(date_b_q));
                pass_d   = 1'b0;
                if (!(valid_a && valid_b)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    y_d     = f_year(date_a_q) - YEAR_W'(1);
                    q4_d    = f_year(date_a_q) - YEAR_W'(1);
                    q100_d  = f_year(date_a_q) - YEAR_W'(1);
                    q400_d  = f_year(date_a_q) - YEAR_W'(1);
                    r4_d    = '0;
                    r100_d  = '0;
                    r400_d  = '0;
                    cnt_d   = CNT_W'(YEAR_W - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                {r4_d,   q4_d}   = div_step({r4_q,   q4_q},   REM_W'(4));
                {r100_d, q100_d} = div_step({r100_q, q100_q}, REM_W'(100));
                {r400_d, q400_d} = div_step({r400_q, q400_q}, REM_W'(400));
                if (cnt_q == '0) begin
                    state_d = S_ACCUM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCUM: begin
                if (!mode_q) begin
                    result_d = {1'b0, acc_sum};
                    state_d  = S_DONE;
                end else if (!pass_q) begin
                    d_a_d   = acc_sum;
                    pass_d  = 1'b1;
                    y_d     = f_year(date_b_q) - YEAR_W'(1);
                    q4_d    = f_year(date_b_q) - YEAR_W'(1);
                    q100_d  = f_year(date_b_q) - YEAR_W'(1);
                    q400_d  = f_year(date_b_q) - YEAR_W'(1);
                    r4_d    = '0;
                    r100_d  = '0;
                    r400_d  = '0;
                    cnt_d   = CNT_W'(YEAR_W - 1);
                    state_d = S_DIV;
                end else begin
                    result_d = {1'b0, d_a_q} - {1'b0, acc_sum};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q == S_VALIDATE) || (state_q == S_DIV) || (state_q == S_ACCUM);
    assign bus.done   = (state_q == S_DONE);
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_days_sum_seq.sv
// tb_days_sum_seq: directed and randomized checks of days_sum_seq against a
// calendar model (leap rule + month lengths) kept in the bench.
`timescale 1ns/1ps
module tb_days_sum_seq;
    localparam int YW  = 14;
    localparam int DW  = 23;
    localparam int DTW = YW + 9;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    days_sum_if #(.YEAR_W(YW), .DAYS_W(DW)) bus ();

    days_sum_seq #(.YEAR_W(YW), .DAYS_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectations for accepted operations, in start order.
    bit            q_err[$];
    logic [DW:0]   q_res[$];
    int            q_lat[$];
    int            q_t0[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      nm, act, act, exp, exp, cyc);
    endtask

    // ---------------- calendar model ----------------
    function automatic bit m_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_mlen(input int y, input int m);
        case (m)
            2:           return m_leap(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic bit m_ok(input logic [DTW-1:0] d);
        int y, m, dd;
        y  = int'(d[DTW-1:9]);
        m  = int'(d[8:5]);
        dd = int'(d[4:0]);
        if (y == 0 || m < 1 || m > 12 || dd < 1) return 1'b0;
        return dd <= m_mlen(y, m);
    endfunction

    // Days in all complete years before y, plus complete months, plus the day.
    function automatic int m_days(input int y, input int m, input int d);
        int n;
        n = 365 * (y - 1) + (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400;
        for (int k = 1; k < m; k++) n += m_mlen(y, k);
        return n + d;
    endfunction

    function automatic int m_days_p(input logic [DTW-1:0] d);
        return m_days(int'(d[DTW-1:9]), int'(d[8:5]), int'(d[4:0]));
    endfunction

    function automatic logic [DTW-1:0] pack(input int y, input int m, input int d);
        return {YW'(y), 4'(m), 5'(d)};
    endfunction

    function automatic logic [DTW-1:0] rand_valid();
        int y, m;
        y = int'($urandom_range(1, (1 << YW) - 1));
        m = int'($urandom_range(1, 12));
        return pack(y, m, int'($urandom_range(1, m_mlen(y, m))));
    endfunction

    task automatic model_op(input bit m, input logic [DTW-1:0] a, input logic [DTW-1:0] b,
                            output bit e, output logic [DW:0] r, output int lat);
        if (!m_ok(a) || (m && !m_ok(b))) begin
            e = 1'b1; r = '0; lat = 2;
        end else if (!m) begin
            e = 1'b0; r = (DW+1)'(m_days_p(a)); lat = YW + 3;
        end else begin
            e = 1'b0; r = (DW+1)'(m_days_p(a) - m_days_p(b)); lat = 2 * YW + 4;
        end
    endtask

    // ---------------- compare process ----------------
    int          busy_cnt;
    logic [DW:0] last_res;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            last_res = '0;
        end else begin
            if (bus.busy) begin
                busy_cnt++;
                chk("result_hold_while_busy", 64'(bus.result), 64'(last_res));
            end
            if (bus.done) begin
                if (q_err.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    bit          e;
                    logic [DW:0] r;
                    int          lat, t0;
                    e = q_err.pop_front(); r = q_res.pop_front();
                    lat = q_lat.pop_front(); t0 = q_t0.pop_front();
                    chk("result", 64'(bus.result), 64'(r));
                    chk("err", 64'(bus.err), 64'(e));
                    chk("latency", 64'(cyc - t0), 64'(lat));
                    chk("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
                    chk("busy_low_at_done", 64'(bus.busy), 64'(0));
                    last_res = r;
                end
                busy_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input bit m, input logic [DTW-1:0] a, input logic [DTW-1:0] b,
                         input bit spam);
        bit          e;
        logic [DW:0] r;
        int          lat;
        bit          seen;
        model_op(m, a, b, e, r, lat);
        @(negedge clk);
        q_err.push_back(e); q_res.push_back(r); q_lat.push_back(lat); q_t0.push_back(cyc);
        bus.start = 1'b1; bus.mode = m; bus.date_a = a; bus.date_b = b;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 3 * YW + 20; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spam) begin
                bus.mode   = 1'($urandom_range(0, 1));
                bus.date_a = rand_valid();
                bus.date_b = rand_valid();
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 64'(0), 64'(1));
            if (q_err.size() > 0) begin
                void'(q_err.pop_front()); void'(q_res.pop_front());
                void'(q_lat.pop_front()); void'(q_t0.pop_front());
            end
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.date_a = '0; bus.date_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_err", 64'(bus.err), 64'(0));
        chk("reset_result", 64'(bus.result), 64'(0));
        rst = 1'b0;

        // Hand-computed anchors for the model (1900 is not a leap year).
        chk("model_0001_01_01", 64'(m_days(1, 1, 1)), 64'(1));
        chk("model_2000_01_01", 64'(m_days(2000, 1, 1)), 64'(730120));
        chk("model_2024_03_01", 64'(m_days(2024, 3, 1)), 64'(738946));
        chk("model_1900_03_01", 64'(m_days(1900, 3, 1)), 64'(693655));
        chk("model_diff", 64'(m_days(2024, 3, 1) - m_days(2000, 1, 1)), 64'(8826));
        chk("model_2023_02_29_invalid", 64'(m_ok(pack(2023, 2, 29))), 64'(0));

        do_op(1'b0, pack(1, 1, 1), '0, 1'b0);
        do_op(1'b0, pack(2000, 1, 1), '0, 1'b0);
        do_op(1'b0, pack(2024, 3, 1), '0, 1'b0);
        do_op(1'b0, pack(1900, 3, 1), '0, 1'b0);
        do_op(1'b0, pack((1 << YW) - 1, 12, 31), '0, 1'b0);
        do_op(1'b1, pack(2024, 3, 1), pack(2000, 1, 1), 1'b0);
        do_op(1'b1, pack(2000, 1, 1), pack(2024, 3, 1), 1'b0);
        do_op(1'b1, pack(2024, 2, 29), pack(2024, 2, 29), 1'b0);

        do_op(1'b0, pack(2023, 2, 29), '0, 1'b0);
        do_op(1'b0, pack(2023, 13, 1), '0, 1'b0);
        do_op(1'b0, pack(2023, 5, 0), '0, 1'b0);
        do_op(1'b0, pack(0, 5, 10), '0, 1'b0);
        do_op(1'b1, pack(2023, 5, 10), pack(2023, 4, 31), 1'b0);
        do_op(1'b0, pack(2000, 2, 29), '0, 1'b0);

        // start hammered while busy must be ignored
        do_op(1'b1, pack(1999, 12, 31), pack(1, 1, 1), 1'b1);
        do_op(1'b0, pack(1600, 6, 15), '0, 1'b1);

        // Reset in the middle of DIV: outputs drop at once, no done follows.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.date_a = pack(2024, 3, 1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_div", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(bus.busy), 64'(0));
        chk("async_rst_done", 64'(bus.done), 64'(0));
        chk("async_rst_result", 64'(bus.result), 64'(0));
        chk("async_rst_err", 64'(bus.err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * YW + 10) @(negedge clk);
        do_op(1'b0, pack(2024, 3, 1), '0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit               m;
            logic [DTW-1:0]   a, b;
            m = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? DTW'($urandom) : rand_valid();
            b = ($urandom_range(0, 7) == 0) ? DTW'($urandom) : rand_valid();
            do_op(m, a, b, $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        chk("all_ops_completed", 64'(q_err.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
